// File: rtl/external_memory_scheduler.sv
// Time-slot scheduler sharing one SRAM port between N_CLIENTS delay-line clients.
// Ports: tick in, per-client addr/data/we in, per-client readdata/valid out, mem_* bus, busy/done/overrun.
module external_memory_scheduler #(
  parameter int N_CLIENTS    = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 21,
  parameter int READ_LATENCY = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sample_tick_i,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cl_read_address_i,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cl_write_address_i,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  cl_writedata_i,
  input  logic [N_CLIENTS-1:0]             cl_write_enable_i,
  output logic [N_CLIENTS*DATA_WIDTH-1:0]  cl_readdata_o,
  output logic [N_CLIENTS-1:0]             cl_readdata_valid_o,
  output logic [ADDR_WIDTH-1:0]            mem_read_address_o,
  output logic [ADDR_WIDTH-1:0]            mem_write_address_o,
  output logic [DATA_WIDTH-1:0]            mem_writedata_o,
  output logic                             mem_write_enable_o,
  input  logic [DATA_WIDTH-1:0]            mem_readdata_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overrun_o
);

  localparam int SW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [SW-1:0] LAST_SLOT  = SW'(N_CLIENTS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(READ_LATENCY - 1);

  typedef logic [N_CLIENTS-1:0][ADDR_WIDTH-1:0] addr_vec_t;
  typedef logic [N_CLIENTS-1:0][DATA_WIDTH-1:0] data_vec_t;
  typedef logic [READ_LATENCY-1:0][SW-1:0]      tag_vec_t;

  logic [1:0]              state_q, state_d;
  logic [SW-1:0]           slot_q, slot_d, nxt_slot;
  logic [CW-1:0]           drain_q, drain_d;
  addr_vec_t               snap_ra_q, snap_ra_d;
  addr_vec_t               snap_wa_q, snap_wa_d;
  data_vec_t               snap_wd_q, snap_wd_d;
  logic [N_CLIENTS-1:0]    snap_we_q, snap_we_d;
  logic [ADDR_WIDTH-1:0]   mem_ra_q, mem_ra_d;
  logic [ADDR_WIDTH-1:0]   mem_wa_q, mem_wa_d;
  logic [DATA_WIDTH-1:0]   mem_wd_q, mem_wd_d;
  logic                    mem_we_q, mem_we_d;
  logic [READ_LATENCY-1:0] tag_v_q, tag_v_d;
  tag_vec_t                tag_s_q, tag_s_d;
  data_vec_t               rd_q, rd_d;
  logic [N_CLIENTS-1:0]    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    busy, start;

  // busy spans the done cycle so a tick landing there is rejected
  assign busy  = (state_q != S_IDLE) | done_q;
  assign start = sample_tick_i & ~busy;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    drain_d   = drain_q;
    snap_ra_d = snap_ra_q;
    snap_wa_d = snap_wa_q;
    snap_wd_d = snap_wd_q;
    snap_we_d = snap_we_q;
    mem_ra_d  = '0;
    mem_wa_d  = '0;
    mem_wd_d  = '0;
    mem_we_d  = 1'b0;
    rd_d      = rd_q;
    valid_d   = '0;
    done_d    = 1'b0;
    nxt_slot  = slot_q + SW'(1);

    // slot tag follows each read request through the memory latency
    tag_v_d[0] = (state_q == S_SERVE);
    tag_s_d[0] = slot_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_s_d[i] = tag_s_q[i-1];
    end

    if (tag_v_q[READ_LATENCY-1]) begin
      rd_d[tag_s_q[READ_LATENCY-1]]    = mem_readdata_i;
      valid_d[tag_s_q[READ_LATENCY-1]] = 1'b1;
      done_d = (tag_s_q[READ_LATENCY-1] == LAST_SLOT);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_ra_d = cl_read_address_i;
          snap_wa_d = cl_write_address_i;
          snap_wd_d = cl_writedata_i;
          snap_we_d = cl_write_enable_i;
          // slot 0 goes straight from the inputs to hit t+1
          mem_ra_d  = cl_read_address_i[ADDR_WIDTH-1:0];
          mem_wa_d  = cl_write_address_i[ADDR_WIDTH-1:0];
          mem_wd_d  = cl_writedata_i[DATA_WIDTH-1:0];
          mem_we_d  = cl_write_enable_i[0];
          slot_d    = '0;
          state_d   = S_SERVE;
        end
      end
      S_SERVE: begin
        if (slot_q == LAST_SLOT) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          slot_d   = nxt_slot;
          mem_ra_d = snap_ra_q[nxt_slot];
          mem_wa_d = snap_wa_q[nxt_slot];
          mem_wd_d = snap_wd_q[nxt_slot];
          mem_we_d = snap_we_q[nxt_slot];
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = S_IDLE;
        else drain_d = drain_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      drain_q   <= '0;
      snap_ra_q <= '0;
      snap_wa_q <= '0;
      snap_wd_q <= '0;
      snap_we_q <= '0;
      mem_ra_q  <= '0;
      mem_wa_q  <= '0;
      mem_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      tag_v_q   <= '0;
      tag_s_q   <= '0;
      rd_q      <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      drain_q   <= drain_d;
      snap_ra_q <= snap_ra_d;
      snap_wa_q <= snap_wa_d;
      snap_wd_q <= snap_wd_d;
      snap_we_q <= snap_we_d;
      mem_ra_q  <= mem_ra_d;
      mem_wa_q  <= mem_wa_d;
      mem_wd_q  <= mem_wd_d;
      mem_we_q  <= mem_we_d;
      tag_v_q   <= tag_v_d;
      tag_s_q   <= tag_s_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign cl_readdata_o       = rd_q;
  assign cl_readdata_valid_o = valid_q;
  assign mem_read_address_o  = mem_ra_q;
  assign mem_write_address_o = mem_wa_q;
  assign mem_writedata_o     = mem_wd_q;
  assign mem_write_enable_o  = mem_we_q;
  assign busy_o              = busy;
  assign done_o              = done_q;
  assign overrun_o           = sample_tick_i & busy;

endmodule

// File: tb/tb_external_memory_scheduler.sv
// Scoreboard bench for external_memory_scheduler.
// Reference: clients served in order against an abstract memory array.
module tb_external_memory_scheduler;

  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 16;
  localparam int RL = 2;

  typedef struct {
    int            cyc;
    int            k;
    logic [DW-1:0] data;
  } rd_ev_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we;
  } mem_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [N-1:0][AW-1:0] cl_ra = '0;
  logic [N-1:0][AW-1:0] cl_wa = '0;
  logic [N-1:0][DW-1:0] cl_wd = '0;
  logic [N-1:0]         cl_we = '0;
  logic [N*DW-1:0]      cl_rd;
  logic [N-1:0]         cl_vld;
  logic [AW-1:0]        m_ra, m_wa;
  logic [DW-1:0]        m_wd;
  logic                 m_we;
  logic [DW-1:0]        m_rd;
  logic                 busy, done, overrun;

  external_memory_scheduler #(
    .N_CLIENTS(N), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sample_tick_i(tick),
    .cl_read_address_i(cl_ra),
    .cl_write_address_i(cl_wa),
    .cl_writedata_i(cl_wd),
    .cl_write_enable_i(cl_we),
    .cl_readdata_o(cl_rd),
    .cl_readdata_valid_o(cl_vld),
    .mem_read_address_o(m_ra),
    .mem_write_address_o(m_wa),
    .mem_writedata_o(m_wd),
    .mem_write_enable_o(m_we),
    .mem_readdata_i(m_rd),
    .busy_o(busy),
    .done_o(done),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // board SRAM: 2-cycle read, old data on read-during-write
  bit [DW-1:0] pmem [1024];
  logic [DW-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (m_we) pmem[m_wa[9:0]] <= m_wd;
    p1 <= pmem[m_ra[9:0]];
    p2 <= p1;
  end
  assign m_rd = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [DW-1:0] ref_mem [1024];
  logic [N-1:0][DW-1:0] hold_m = '0;
  rd_ev_t  rdq[$];
  mem_ev_t mq[$];
  int      doneq[$];
  bit fv = 0;
  int fs = 0, fe = 0;
  int checks = 0, errors = 0;
  bit mon_en = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit busy_exp(int c);
    return fv && c > fs && c <= fe;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [N-1:0] vm;
      bit dn, bz;
      rd_ev_t r;
      mem_ev_t m;
      vm = '0;
      while (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        r = rdq.pop_front();
        vm[r.k] = 1'b1;
        hold_m[r.k] = r.data;
      end
      chk("valid", cl_vld, vm);
      chk("readdata", cl_rd, hold_m);
      dn = 0;
      if (doneq.size() > 0 && doneq[0] == cyc) begin
        void'(doneq.pop_front());
        dn = 1;
      end
      chk("done", done, dn);
      bz = busy_exp(cyc);
      chk("busy", busy, bz);
      chk("overrun", overrun, tick & bz);
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        m = mq.pop_front();
        chk("mem_ra", m_ra, m.ra);
        chk("mem_we", m_we, m.we);
        if (m.we) begin
          chk("mem_wa", m_wa, m.wa);
          chk("mem_wd", m_wd, m.wd);
        end
      end else begin
        chk("mem_we_idle", m_we, 1'b0);
        if (!bz) chk("mem_bus_idle", {m_ra, m_wa, m_wd}, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  // the reference serves clients in order: read, then write
  task automatic accept();
    logic [DW-1:0] d;
    fv = 1;
    fs = cyc;
    fe = cyc + 1 + N + RL;
    for (int k = 0; k < N; k++) begin
      mq.push_back('{cyc + 1 + k, cl_ra[k], cl_wa[k], cl_wd[k], cl_we[k]});
      d = ref_mem[cl_ra[k][9:0]];
      if (cl_we[k]) ref_mem[cl_wa[k][9:0]] = cl_wd[k];
      rdq.push_back('{cyc + 2 + k + RL, k, d});
    end
    doneq.push_back(fe);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    if (!busy_exp(cyc)) accept();
    step();
    tick = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < N; k++) begin
      cl_ra[k] = AW'($urandom_range(0, 15));
      cl_wa[k] = AW'($urandom_range(0, 15));
      cl_wd[k] = DW'($urandom);
      cl_we[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_inputs();
    cl_ra = '0;
    cl_wa = '0;
    cl_wd = '0;
    cl_we = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdq.delete();
    mq.delete();
    doneq.delete();
    hold_m = '0;
    fv = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  int base;

  initial begin
    step();
    mon_en = 1;
    step();
    rst = 1'b0;
    // idle after reset
    repeat (20) step();

    // preload 100..103 through a write frame
    for (int k = 0; k < N; k++) begin
      cl_wa[k] = AW'(100 + k);
      cl_wd[k] = DW'(16'hA0 + k);
      cl_we[k] = 1'b1;
    end
    do_tick();
    repeat (10) step();

    // read back 100..103, tick at base+10
    base = cyc;
    clear_inputs();
    for (int k = 0; k < N; k++) cl_ra[k] = AW'(100 + k);
    wait_until(base + 10);
    do_tick();
    repeat (10) step();

    // client 2 writes 5, then same-slot read/write of 5
    clear_inputs();
    cl_wa[2] = AW'(5);
    cl_wd[2] = 16'h1234;
    cl_we[2] = 1'b1;
    do_tick();
    repeat (10) step();
    clear_inputs();
    cl_ra[0] = AW'(5);
    cl_ra[1] = AW'(5);
    cl_wa[1] = AW'(5);
    cl_wd[1] = 16'h5555;
    cl_we[1] = 1'b1;
    do_tick();
    repeat (10) step();
    clear_inputs();
    cl_ra[0] = AW'(5);
    do_tick();
    repeat (10) step();

    // overrun ticks and post-tick input changes
    base = cyc;
    rand_inputs();
    wait_until(base + 10);
    do_tick();
    rand_inputs();
    wait_until(base + 14);
    do_tick();
    wait_until(base + 17);
    do_tick();
    rand_inputs();
    do_tick();
    rand_inputs();
    repeat (10) step();

    // mid-frame reset
    base = cyc;
    clear_inputs();
    for (int k = 0; k < N; k++) cl_ra[k] = AW'(100 + k);
    wait_until(base + 10);
    do_tick();
    wait_until(base + 13);
    do_reset();
    repeat (10) step();
    do_tick();
    repeat (10) step();

    // random traffic
    for (int it = 0; it < 400; it++) begin
      rand_inputs();
      if ($urandom_range(0, 4) == 0) do_tick();
      else step();
    end
    tick = 1'b0;
    repeat (20) step();
    chk("rdq_empty", 128'(rdq.size()), '0);
    chk("mq_empty", 128'(mq.size()), '0);
    chk("doneq_empty", 128'(doneq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
